// File: rtl/updown_bcd_counter.sv
// Up/down event counter with synchronised hit/ud inputs, modulo limit,
// wrap/saturate mode, parallel load, and a registered packed-BCD mirror of the count.
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_hit        asynchronous count request, one count per rising edge
//   i_ud         direction, 0 = up, 1 = down (synchronised alongside i_hit)
//   i_load       synchronous parallel load strobe (wins over a count event)
//   i_load_val   binary load value, clamped to MAX_VAL
//   o_count_bin  current count, binary
//   o_cout       current count, packed BCD, digit 0 in [3:0]
//   o_carry      1-clk pulse on up-wrap MAX_VAL -> 0
//   o_borrow     1-clk pulse on down-wrap 0 -> MAX_VAL
//   o_at_max     count == MAX_VAL
//   o_at_zero    count == 0
module updown_bcd_counter #(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned MAX_VAL     = 99,
  parameter int unsigned SAT_MODE    = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned W           = 7
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_hit,
  input  logic                  i_ud,
  input  logic                  i_load,
  input  logic [W-1:0]          i_load_val,
  output logic [W-1:0]          o_count_bin,
  output logic [4*DIGITS-1:0]   o_cout,
  output logic                  o_carry,
  output logic                  o_borrow,
  output logic                  o_at_max,
  output logic                  o_at_zero
);

  localparam int unsigned BW = 4 * DIGITS;

  // Double-dabble binary to packed BCD; used for the load path and the wrap constant.
  function automatic logic [BW-1:0] f_bin2bcd(input logic [W-1:0] v);
    logic [BW-1:0] bcd;
    bcd = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[BW-2:0], v[i]};
    end
    return bcd;
  endfunction

  localparam logic [W-1:0]  MAX_BIN = W'(MAX_VAL);
  localparam logic [BW-1:0] MAX_BCD = f_bin2bcd(MAX_BIN);

  logic [SYNC_STAGES-1:0] r_hit_sync;
  logic [SYNC_STAGES-1:0] r_ud_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_hit_d;
  logic                   r_armed;
  logic                   r_ev;
  logic                   r_ev_dn;
  logic [W-1:0]           r_count;
  logic [BW-1:0]          r_bcd;
  logic                   r_carry;
  logic                   r_borrow;
  logic                   r_at_max;
  logic                   r_at_zero;

  logic                   w_hit_s;
  logic                   w_ud_s;
  logic [W-1:0]           w_load_clamped;
  logic [BW-1:0]          w_bcd_inc;
  logic [BW-1:0]          w_bcd_dec;
  logic [W-1:0]           w_cnt_nxt;
  logic [BW-1:0]          w_bcd_nxt;
  logic                   w_carry_nxt;
  logic                   w_borrow_nxt;

  assign w_hit_s        = r_hit_sync[SYNC_STAGES-1];
  assign w_ud_s         = r_ud_sync[SYNC_STAGES-1];
  assign w_load_clamped = (i_load_val > MAX_BIN) ? MAX_BIN : i_load_val;

  // Synchronisers, edge detect and event register. r_vld marks when hit_s carries a
  // real sample, so a hit held high through reset release never looks like a 0->1 edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hit_sync <= '0;
      r_ud_sync  <= '0;
      r_vld      <= '0;
      r_hit_d    <= 1'b0;
      r_armed    <= 1'b0;
      r_ev       <= 1'b0;
      r_ev_dn    <= 1'b0;
    end else begin
      r_hit_sync <= {r_hit_sync[SYNC_STAGES-2:0], i_hit};
      r_ud_sync  <= {r_ud_sync[SYNC_STAGES-2:0], i_ud};
      r_vld      <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_hit_d    <= w_hit_s;
      r_armed    <= r_armed | (r_vld[SYNC_STAGES-1] & ~w_hit_s);
      r_ev       <= r_armed & w_hit_s & ~r_hit_d;
      r_ev_dn    <= w_ud_s;
    end
  end

  // Digit-wise BCD increment/decrement with combinational ripple between digits.
  always_comb begin
    logic ci;
    logic bi;
    w_bcd_inc = r_bcd;
    w_bcd_dec = r_bcd;
    ci        = 1'b1;
    bi        = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (ci) begin
        if (r_bcd[4*d +: 4] == 4'd9) begin
          w_bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
          ci                  = 1'b0;
        end
      end
      if (bi) begin
        if (r_bcd[4*d +: 4] == 4'd0) begin
          w_bcd_dec[4*d +: 4] = 4'd9;
        end else begin
          w_bcd_dec[4*d +: 4] = r_bcd[4*d +: 4] - 4'd1;
          bi                  = 1'b0;
        end
      end
    end
  end

  // Next count: load > event > hold. Binary and BCD always move together.
  always_comb begin
    w_cnt_nxt    = r_count;
    w_bcd_nxt    = r_bcd;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    if (i_load) begin
      w_cnt_nxt = w_load_clamped;
      w_bcd_nxt = f_bin2bcd(w_load_clamped);
    end else if (r_ev) begin
      if (!r_ev_dn) begin
        if (r_count == MAX_BIN) begin
          if (SAT_MODE == 0) begin
            w_cnt_nxt   = '0;
            w_bcd_nxt   = '0;
            w_carry_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_count + W'(1);
          w_bcd_nxt = w_bcd_inc;
        end
      end else begin
        if (r_count == '0) begin
          if (SAT_MODE == 0) begin
            w_cnt_nxt    = MAX_BIN;
            w_bcd_nxt    = MAX_BCD;
            w_borrow_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_count - W'(1);
          w_bcd_nxt = w_bcd_dec;
        end
      end
    end
  end

  // Count, BCD mirror and flags, all registered together.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count   <= '0;
      r_bcd     <= '0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_at_max  <= 1'b0;
      r_at_zero <= 1'b1;
    end else begin
      r_count   <= w_cnt_nxt;
      r_bcd     <= w_bcd_nxt;
      r_carry   <= w_carry_nxt;
      r_borrow  <= w_borrow_nxt;
      r_at_max  <= (w_cnt_nxt == MAX_BIN);
      r_at_zero <= (w_cnt_nxt == '0);
    end
  end

  assign o_count_bin = r_count;
  assign o_cout      = r_bcd;
  assign o_carry     = r_carry;
  assign o_borrow    = r_borrow;
  assign o_at_max    = r_at_max;
  assign o_at_zero   = r_at_zero;

endmodule
